// File: rtl/j24_sweep_ctrl.sv
// Exhaustive-sweep sequencer: walks every WIDTH-bit vector PASSES times, samples the
// DUT output after SETTLE cycles and streams (index, vector, z) records over valid/ready.
module j24_sweep_ctrl #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned PASSES = 2,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned CNT_W  = WIDTH + 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] stim,
  input  logic             z_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_index,
  output logic [WIDTH-1:0] out_vector,
  output logic             out_z,
  output logic             busy,
  output logic             done
);

  localparam int unsigned      SET_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(PASSES * (2 ** WIDTH) - 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_EMIT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   stim_q, stim_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [WIDTH-1:0]   vec_q, vec_d;
  logic               z_q, z_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // State and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      stim_q   <= '0;
      idx_q    <= '0;
      settle_q <= '0;
      vec_q    <= '0;
      z_q      <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      stim_q   <= stim_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      vec_q    <= vec_d;
      z_q      <= z_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and next-output logic; status flags are decoded from the next state
  always_comb begin
    state_d  = state_q;
    stim_d   = stim_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    vec_d    = vec_q;
    z_d      = z_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_DRIVE;
          stim_d   = '0;
          idx_d    = '0;
          settle_d = '0;
        end
      end
      S_DRIVE: begin
        if (settle_q == SETTLE_LAST) begin
          z_d     = z_in;
          vec_d   = stim_q;
          state_d = S_EMIT;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d    = idx_q + CNT_W'(1);
            stim_d   = stim_q + WIDTH'(1);
            settle_d = '0;
            state_d  = S_DRIVE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // abort wins over start and over a completing handshake
    if (abort) begin
      state_d  = S_IDLE;
      stim_d   = stim_q;
      idx_d    = idx_q;
      settle_d = settle_q;
      vec_d    = vec_q;
      z_d      = z_q;
    end

    valid_d = (state_d == S_EMIT);
    busy_d  = (state_d == S_DRIVE) || (state_d == S_EMIT);
    done_d  = (state_d == S_DONE);
  end

  assign stim       = stim_q;
  assign out_index  = idx_q;
  assign out_vector = vec_q;
  assign out_z      = z_q;
  assign out_valid  = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_j24_sweep_ctrl.sv
// Bench for j24_sweep_ctrl: WIDTH=4/PASSES=2 sweeps with SETTLE=1 and SETTLE=3 instances.
module tb_j24_sweep_ctrl;

  localparam int W  = 4;
  localparam int P  = 2;
  localparam int NV = 1 << W;
  localparam int N  = P * NV;
  localparam int CW = W + 2;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  // SETTLE=1 instance, z = parity of stim
  logic          start, abort, out_ready, z_in;
  logic [W-1:0]  stim, out_vector;
  logic [CW-1:0] out_index;
  logic          out_valid, out_z, busy, done;

  // SETTLE=3 instance, z = parity of stim through a 2-cycle delay
  logic          start3, abort3, ready3, z3, z3_d1, z3_d2;
  logic [W-1:0]  stim3, vec3;
  logic [CW-1:0] idx3;
  logic          valid3, oz3, busy3, done3;

  assign z_in = ^stim;
  assign z3   = z3_d2;
  always @(posedge clock) begin
    z3_d1 <= ^stim3;
    z3_d2 <= z3_d1;
  end

  j24_sweep_ctrl #(.WIDTH(W), .PASSES(P), .SETTLE(1), .CNT_W(CW)) u_dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort), .stim(stim),
    .z_in(z_in), .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .out_vector(out_vector), .out_z(out_z), .busy(busy), .done(done)
  );

  j24_sweep_ctrl #(.WIDTH(W), .PASSES(P), .SETTLE(3), .CNT_W(CW)) u_dut3 (
    .clock(clock), .reset_n(reset_n), .start(start3), .abort(abort3), .stim(stim3),
    .z_in(z3), .out_valid(valid3), .out_ready(ready3), .out_index(idx3),
    .out_vector(vec3), .out_z(oz3), .busy(busy3), .done(done3)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_stim", 32'(stim), 32'd0);
    check("start_index", 32'(out_index), 32'd0);
    check("start_done_clr", 32'(done), 32'd0);
  endtask

  // Drive one run on the SETTLE=1 instance and score every record against k-th expected record.
  task automatic collect(input bit rand_rdy, input int abort_at);
    int k = 0;
    int cyc = 0;
    int last_hs = -1;
    bit first_seen = 0;
    bit held = 0;
    bit stopped = 0;
    bit aborted = 0;
    logic [CW-1:0] h_idx;
    logic [W-1:0]  h_vec, ev;
    logic          h_z;
    while (!stopped && cyc < 2000) begin
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      start = 1'b0;
      abort = 1'b0;
      if (held) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_index", 32'(out_index), 32'(h_idx));
        check("stall_vector", 32'(out_vector), 32'(h_vec));
        check("stall_z", 32'(out_z), 32'(h_z));
      end
      held = 0;
      if (out_valid) begin
        if (!first_seen) begin
          first_seen = 1;
          check("first_valid_latency", 32'(cyc), 32'd1);
        end
        if (abort_at >= 0 && k == 5) start = 1'b1;
        if (abort_at == k) begin
          abort = 1'b1;
          out_ready = 1'b1;
        end else if (out_ready) begin
          ev = W'(k % NV);
          check("rec_index", 32'(out_index), 32'(k));
          check("rec_vector", 32'(out_vector), 32'(ev));
          check("rec_z", 32'(out_z), 32'(^ev));
          if (!rand_rdy && last_hs >= 0) check("rec_spacing", 32'(cyc - last_hs), 32'd2);
          last_hs = cyc;
          k++;
        end else begin
          held  = 1;
          h_idx = out_index;
          h_vec = out_vector;
          h_z   = out_z;
        end
      end
      tick();
      cyc++;
      if (abort) begin
        aborted = 1;
        stopped = 1;
      end else if (done) begin
        stopped = 1;
      end
    end
    abort = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;
    if (aborted) begin
      check("abort_valid", 32'(out_valid), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_index_kept", 32'(out_index), 32'(abort_at));
      check("abort_stim_kept", 32'(stim), 32'(abort_at % NV));
    end else begin
      check("done_seen", 32'(done), 32'd1);
      check("record_count", 32'(k), 32'(N));
      check("done_latency", 32'(cyc - last_hs), 32'd1);
    end
  endtask

  initial begin
    int cyc;
    int k;
    int last_hs;
    logic [W-1:0] ev;

    reset_n = 1'b0;
    start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    start3 = 1'b0; abort3 = 1'b0; ready3 = 1'b1;
    #12;
    check("rst_stim", 32'(stim), 32'd0);
    check("rst_index", 32'(out_index), 32'd0);
    check("rst_vector", 32'(out_vector), 32'd0);
    check("rst_z", 32'(out_z), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) tick();
    check("idle_no_start_busy", 32'(busy), 32'd0);

    // Full run, ready always high
    pulse_start();
    collect(1'b0, -1);
    repeat (3) tick();
    check("done_hold", 32'(done), 32'd1);
    check("final_index_hold", 32'(out_index), 32'(N - 1));
    check("done_no_valid", 32'(out_valid), 32'd0);

    // Same run with random backpressure
    pulse_start();
    collect(1'b1, -1);

    // start while busy at index 5, abort during EMIT at index 9, then restart
    pulse_start();
    collect(1'b0, 9);
    tick();
    check("idle_after_abort", 32'(busy), 32'd0);
    pulse_start();
    collect(1'b0, -1);

    // Asynchronous reset while in DRIVE at index 20
    pulse_start();
    cyc = 0;
    while (!(busy && !out_valid && out_index == CW'(20)) && cyc < 200) begin
      tick();
      cyc++;
    end
    check("reached_idx20_drive", 32'(out_index), 32'd20);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_stim", 32'(stim), 32'd0);
    check("mid_rst_index", 32'(out_index), 32'd0);
    check("mid_rst_vector", 32'(out_vector), 32'd0);
    check("mid_rst_z", 32'(out_z), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_quiet_valid", 32'(out_valid), 32'd0);
      check("post_rst_quiet_busy", 32'(busy), 32'd0);
    end
    pulse_start();
    collect(1'b0, -1);

    // SETTLE=3 instance with delayed z
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    check("s3_start_busy", 32'(busy3), 32'd1);
    cyc = 0;
    k = 0;
    last_hs = -1;
    while (!done3 && cyc < 2000) begin
      if (valid3) begin
        ev = W'(k % NV);
        if (k == 0) check("s3_first_latency", 32'(cyc), 32'd3);
        check("s3_index", 32'(idx3), 32'(k));
        check("s3_vector", 32'(vec3), 32'(ev));
        check("s3_z", 32'(oz3), 32'(^ev));
        if (last_hs >= 0) check("s3_spacing", 32'(cyc - last_hs), 32'd4);
        last_hs = cyc;
        k++;
      end
      tick();
      cyc++;
    end
    check("s3_done", 32'(done3), 32'd1);
    check("s3_count", 32'(k), 32'(N));
    check("s3_done_latency", 32'(cyc - last_hs), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
